addsub_seq_nbit: RTL and testbench



---
 rtl/addsub_pkg.sv | 13 +
 rtl/fa_chunk.sv | 43 ++++
 rtl/addsub_seq_nbit.sv | 113 +++++++++++
 tb/tb_addsub_seq_nbit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_chunk.sv
// W-bit ripple slice built from single-bit full adder cells.

// Single-bit full adder cell.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module fa_chunk #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb
);
   logic [W:0] c;

   assign c[0] = cin;

   // Carry ripples bit by bit through the slice.
   for (genvar i = 0; i < int'(W); i++) begin : g_bit
      fa_cell u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[W];
   // Carry into the top bit, needed for signed-overflow detection.
   assign c_msb = c[W-1];
endmodule

// File: rtl/addsub_seq_nbit.sv
// Multi-cycle N-bit adder/subtractor: W bits per clock with a registered carry.
module addsub_seq_nbit
   import addsub_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);
   localparam int unsigned SLICES = (W >= 1) ? N / W : 1;
   localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

   // Reject parameter sets that cannot be split into whole slices.
   if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $fatal(1, "addsub_seq_nbit: N must be a non-zero multiple of W");
   end

   state_t         state;
   logic [N-1:0]   opa;
   logic [N-1:0]   opb;
   logic [N-1:0]   acc;
   logic [N-1:0]   acc_next;
   logic           carry;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   slice_sum;
   logic           slice_cout;
   logic           slice_cmsb;
   logic           last;

   fa_chunk #(.W(W)) u_slice (
      .a     (opa[W-1:0]),
      .b     (opb[W-1:0]),
      .cin   (carry),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
   );

   // New slice enters at the top; after the last slice the accumulator is in order.
   if (N == W) begin : g_acc_single
      assign acc_next = slice_sum;
   end else begin : g_acc_shift
      assign acc_next = {slice_sum, acc[N-1:W]};
   end

   assign last = (cnt == CW'(SLICES - 1));

   // Control FSM, operand shifters and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  opa   <= a;
                  opb   <= b ^ {N{mode}};
                  carry <= (mode == MODE_SUB);
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= acc_next;
               opa   <= opa >> W;
               opb   <= opb >> W;
               carry <= slice_cout;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  result <= acc_next;
                  cout   <= slice_cout;
                  ovf    <= slice_cout ^ slice_cmsb;
                  zero   <= (acc_next == '0);
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_seq_nbit.sv
// Directed bench for addsub_seq_nbit (N=16/W=4 plus an N=8/W=8 instance).
module tb_addsub_seq_nbit;
   import addsub_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, mode;
   logic [15:0] a, b;
   logic        busy, done, cout, ovf, zero;
   logic [15:0] result;

   logic        start8, mode8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, cout8, ovf8, zero8;
   logic [7:0]  result8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   addsub_seq_nbit #(.N(16), .W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
   );

   addsub_seq_nbit #(.N(8), .W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
   );

   typedef struct {
      logic        mode;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start into the edge that follows, leave start low afterwards.
   task automatic issue(input logic m, input logic [15:0] x, input logic [15:0] y);
      start = 1'b1; mode = m; a = x; b = y;
      tick();
      start = 1'b0;
   endtask

   // Wait for done, counting edges after the start edge and busy-high samples.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 1;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
         if (busy === 1'b1) busy_cnt++;
         if (busy === 1'b1 && done === 1'b1) check("busy_and_done", 1, 0);
      end
   endtask

   vec_t vecs[10];

   initial begin
      int lat, bcnt;
      vecs[0] = '{MODE_ADD, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{MODE_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{MODE_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{MODE_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{MODE_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{MODE_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{MODE_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{MODE_SUB, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{MODE_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{MODE_SUB, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
      start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_busy",   busy,   0);
      check("reset_done",   done,   0);
      check("reset_result", result, 0);
      check("reset_flags",  {cout, ovf, zero}, 0);

      // Table-driven arithmetic checks.
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].mode, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d_busy_at_start", i), busy, 1);
         wait_done(lat, bcnt);
         check($sformatf("v%0d_latency", i), lat, 4);
         check($sformatf("v%0d_busy_cycles", i), bcnt, 4);
         check($sformatf("v%0d_result", i), result, vecs[i].res);
         check($sformatf("v%0d_cout", i), cout, vecs[i].cout);
         check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
         check($sformatf("v%0d_zero", i), zero, vecs[i].zero);
         tick();
         check($sformatf("v%0d_done_pulse", i), done, 0);
         check($sformatf("v%0d_result_hold", i), result, vecs[i].res);
         tick();
      end

      // Start pulsed mid-operation must be ignored.
      issue(MODE_ADD, 16'h1234, 16'h0FCD);
      tick();
      issue(MODE_SUB, 16'hFFFF, 16'h0001);
      a = 16'h5555; b = 16'hAAAA;
      lat = 2;
      while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
      check("midop_latency", lat, 4);
      check("midop_result", result, 16'h2201);
      check("midop_flags", {cout, ovf, zero}, 3'b000);
      tick();
      check("midop_no_rerun", {busy, done}, 2'b00);

      // Start held in the DONE cycle chains straight into RUN.
      issue(MODE_ADD, 16'h0001, 16'h0002);
      wait_done(lat, bcnt);
      check("b2b_first_result", result, 16'h0003);
      start = 1'b1; mode = MODE_SUB; a = 16'h0005; b = 16'h0007;
      tick();
      start = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_done_low", done, 0);
      check("b2b_result_hold", result, 16'h0003);
      wait_done(lat, bcnt);
      check("b2b_latency", lat, 4);
      check("b2b_second_result", result, 16'hFFFE);
      tick();

      // Reset during the 2nd RUN cycle abandons the operation.
      issue(MODE_ADD, 16'h7FFF, 16'h0001);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", {cout, ovf, zero}, 0);
      begin
         int seen = 0;
         for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
         end
         check("rst_no_done", seen, 0);
      end

      // Single-slice configuration: done one edge after start.
      start8 = 1'b1; mode8 = MODE_ADD; a8 = 8'h7F; b8 = 8'h01;
      tick();
      start8 = 1'b0;
      check("n8_busy", busy8, 1);
      tick();
      check("n8_done", done8, 1);
      check("n8_busy_low", busy8, 0);
      check("n8_result", result8, 8'h80);
      check("n8_ovf", ovf8, 1);
      check("n8_cout", cout8, 0);
      tick();
      check("n8_done_pulse", done8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
